// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU-core types and constants: register-file address
//                geometry, the write-back entry carried between the result
//                buffers, regfile and hazard unit, and the write-port source.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_AW   = 5;   // register-file address width
    localparam int NUM_REGS = 32;  // architectural registers (x0 hardwired)
    localparam int XLEN     = 32;  // native data width of a regfile entry

    // One pending register-file write: destination plus data.
    typedef struct packed {
        logic [REG_AW-1:0] wn;
        logic [XLEN-1:0]   d;
    } wb_entry_t;

    // Which path owns the regfile write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_FIFO = 2'd2,
        WB_LD   = 2'd3
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word fall-through read data.
//                Push and pop in the same cycle are allowed at any occupancy,
//                including full (the popped slot is refilled).
//  Ports       : clk, clr (sync, active-high)
//                push / push_data : write side
//                pop  / pop_data  : read side, pop_data valid when !empty
//                full / empty     : occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2   // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int                c_addr_w   = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full_cnt = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0] c_cnt_one  = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full     = (r_count == c_full_cnt);
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writer
//  Description : Write-side front end of the register file. Merges ALU results
//                (never back-pressured) and long-latency results (buffered in
//                a FIFO when the port is busy) onto the single registered
//                write port, and tracks reserved-but-unwritten destinations
//                to flag read-after-write hazards to the issue stage.
//  Ports       : clk, clr (sync, active-high)
//                alu_we/alu_wn/alu_d         : ALU result
//                ld_valid/ld_ready/ld_wn/ld_d: long-latency result handshake
//                rsv_valid/rsv_wn            : destination reservation
//                rna/rnb -> hza/hzb          : read-address hazard query
//                we/wn/d                     : regfile write port (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_wn,
    input  logic [WIDTH-1:0]  alu_d,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_wn,
    input  logic [WIDTH-1:0]  ld_d,
    input  logic              rsv_valid,
    input  logic [REG_AW-1:0] rsv_wn,
    input  logic [REG_AW-1:0] rna,
    input  logic [REG_AW-1:0] rnb,
    output logic              hza,
    output logic              hzb,
    output logic [REG_AW-1:0] wn,
    output logic [WIDTH-1:0]  d,
    output logic              we
);

    localparam logic [REG_AW-1:0] c_reg0 = '0;

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_ld_fire;
    logic [REG_AW+WIDTH-1:0] w_head;
    wb_src_e                 w_src;
    logic [REG_AW-1:0]       w_sel_wn;
    logic [WIDTH-1:0]        w_sel_d;
    logic [NUM_REGS-1:0]     w_set_mask;
    logic [NUM_REGS-1:0]     w_clr_mask;

    logic                    r_we;
    logic                    r_long;     // output stage holds a long-latency write
    logic [REG_AW-1:0]       r_wn;
    logic [WIDTH-1:0]        r_d;
    logic [NUM_REGS-1:0]     r_pending;

    sync_fifo #(
        .WIDTH (REG_AW + WIDTH),
        .DEPTH (DEPTH)
    ) u_ld_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (w_push),
        .push_data ({ld_wn, ld_d}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Readiness ignores a same-cycle pop so the handshake never depends on
    // the ALU valid; this keeps ld_ready free of long combinational paths.
    assign ld_ready  = !w_fifo_full && !clr;
    assign w_ld_fire = ld_valid && ld_ready;

    // Write-port arbitration: ALU, then FIFO head, then direct bypass.
    always_comb begin
        w_src    = WB_NONE;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_sel_wn = '0;
        w_sel_d  = '0;
        if (alu_we) begin
            w_src    = WB_ALU;
            w_sel_wn = alu_wn;
            w_sel_d  = alu_d;
            w_push   = w_ld_fire;
        end else if (!w_fifo_empty) begin
            w_src    = WB_FIFO;
            w_sel_wn = w_head[WIDTH +: REG_AW];
            w_sel_d  = w_head[WIDTH-1:0];
            w_pop    = 1'b1;
            w_push   = w_ld_fire;
        end else if (w_ld_fire) begin
            w_src    = WB_LD;
            w_sel_wn = ld_wn;
            w_sel_d  = ld_d;
        end
    end

    // Writes to x0 are consumed but never reach the regfile.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_we   <= 1'b0;
            r_long <= 1'b0;
            r_wn   <= '0;
            r_d    <= '0;
        end else begin
            r_we   <= (w_src != WB_NONE) && (w_sel_wn != c_reg0);
            r_long <= (w_src == WB_FIFO) || (w_src == WB_LD);
            r_wn   <= w_sel_wn;
            r_d    <= w_sel_d;
        end
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (rsv_valid && (rsv_wn != c_reg0)) begin
            w_set_mask[rsv_wn] = 1'b1;
        end
        if (r_we && r_long) begin
            w_clr_mask[r_wn] = 1'b1;
        end
    end

    // A new reservation beats the retirement of an older write to the same reg.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // The write in the output stage is not yet readable (no write-through),
    // which also covers the cycle before its pending bit clears.
    assign hza = (rna != c_reg0) && (r_pending[rna] || (r_we && (r_wn == rna)));
    assign hzb = (rnb != c_reg0) && (r_pending[rnb] || (r_we && (r_wn == rnb)));

    assign we = r_we;
    assign wn = r_wn;
    assign d  = r_d;

endmodule
`default_nettype wire
